// File: rtl/rom_sequencer_if.sv
// Purpose : key-flag, ROM and display-side signal bundle of the ROM address sequencer.
// Latency : none, wires only.
// Backpres: none; key flags are single-cycle pulses and the ROM always answers.
// Ports   : slave  = sequencer view (keys and rom_q in; rom_addr, data_out, data_valid, mode out)
//           master = environment view (key filter, ROM and display driver), directions mirrored.
interface rom_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              key_up_flag;
  logic              key_down_flag;
  logic              key_mode_flag;
  logic [DATA_W-1:0] rom_q;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [1:0]        mode;

  modport slave (
    input  key_up_flag, key_down_flag, key_mode_flag, rom_q,
    output rom_addr, data_out, data_valid, mode
  );

  modport master (
    output key_up_flag, key_down_flag, key_mode_flag, rom_q,
    input  rom_addr, data_out, data_valid, mode
  );
endinterface

// File: rtl/rom_sequencer.sv
// Purpose : ROM address sequencer (manual / auto-up / auto-down within [ADDR_MIN, ADDR_MAX])
//           with latency-matched capture of the ROM read data.
// Latency : data_out/data_valid follow a rom_addr change by RD_LAT+1 clocks.
// Backpres: none; every address change produces its own data_valid strobe, in order.
// Ports   : sys_clk, sys_rst (synchronous, active-high) plain;
//           bus (rom_sequencer_if.slave): key_*_flag, rom_q in; rom_addr, data_out, data_valid, mode out.
module rom_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_MIN = 0,
  parameter int ADDR_MAX = 2**ADDR_W - 1,
  parameter int TICK_MAX = 49_999_999,
  parameter int RD_LAT   = 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  rom_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_MANUAL    = 2'b00,
    MODE_AUTO_UP   = 2'b01,
    MODE_AUTO_DOWN = 2'b10
  } mode_e;

  localparam int                TICK_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);
  localparam logic [ADDR_W-1:0] MIN_A     = ADDR_W'(ADDR_MIN);
  localparam logic [ADDR_W-1:0] MAX_A     = ADDR_W'(ADDR_MAX);
  // Window top in the widened domain so the +1 carry out of ADDR_W bits is seen.
  localparam logic [ADDR_W:0]   MAX_X     = (ADDR_W + 1)'(ADDR_MAX);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mode_e             r_mode;
  logic [TICK_W-1:0] r_tick;
  logic [ADDR_W-1:0] r_addr;
  logic              r_req;       // post-reset read request still to be issued
  logic [RD_LAT:0]   r_stb;       // read strobes in flight toward the capture stage
  logic [DATA_W-1:0] r_dat;
  logic              r_vld;

  // ---------------------------------------------------------------------------
  // Key decode and step decision
  // ---------------------------------------------------------------------------
  logic              w_key_up;
  logic              w_key_dn;
  logic              w_tick_wrap;
  logic              w_step;
  logic              w_step_up;
  logic [ADDR_W:0]   w_inc;
  logic [ADDR_W:0]   w_dec;
  logic [ADDR_W-1:0] w_addr_up;
  logic [ADDR_W-1:0] w_addr_dn;
  logic              w_push;

  // Up and down in the same cycle cancel each other in every mode.
  assign w_key_up    = bus.key_up_flag   & ~bus.key_down_flag;
  assign w_key_dn    = bus.key_down_flag & ~bus.key_up_flag;
  assign w_tick_wrap = (r_tick == TICK_LAST);

  // Neighbour addresses, computed one bit wider so neither carry nor borrow is lost.
  assign w_inc = {1'b0, r_addr} + (ADDR_W + 1)'(1);
  assign w_dec = {1'b0, r_addr} - (ADDR_W + 1)'(1);

  assign w_addr_up = (w_inc > MAX_X) ? MIN_A : w_inc[ADDR_W-1:0];
  assign w_addr_dn = ((r_addr == MIN_A) || w_dec[ADDR_W]) ? MAX_A : w_dec[ADDR_W-1:0];

  // A mode key swallows any up/down in the same cycle. In the auto modes a
  // direction key only restarts the period, so a step needs a quiet cycle.
  always_comb begin
    w_step    = 1'b0;
    w_step_up = 1'b0;
    if (!bus.key_mode_flag) begin
      case (r_mode)
        MODE_MANUAL: begin
          if (w_key_up) begin
            w_step    = 1'b1;
            w_step_up = 1'b1;
          end else if (w_key_dn) begin
            w_step    = 1'b1;
          end
        end
        MODE_AUTO_UP: begin
          if (!w_key_up && !w_key_dn && w_tick_wrap) begin
            w_step    = 1'b1;
            w_step_up = 1'b1;
          end
        end
        MODE_AUTO_DOWN: begin
          if (!w_key_up && !w_key_dn && w_tick_wrap) begin
            w_step    = 1'b1;
          end
        end
        default: begin
          w_step    = 1'b0;
          w_step_up = 1'b0;
        end
      endcase
    end
  end

  // The deferred post-reset request and a real address step collapse into one
  // strobe: both ask for the word at the address registered on this edge.
  assign w_push = r_req | w_step;

  // ---------------------------------------------------------------------------
  // Mode FSM, address register, tick counter and read pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_mode <= MODE_MANUAL;
      r_tick <= '0;
      r_addr <= MIN_A;
      r_req  <= 1'b1;
      r_stb  <= '0;
      r_dat  <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_req <= 1'b0;

      // Strobe exits RD_LAT+1 edges after entry; by then the ROM has presented
      // the word for the address that was registered together with the push.
      r_stb <= {r_stb[RD_LAT-1:0], w_push};
      r_vld <= r_stb[RD_LAT];
      if (r_stb[RD_LAT]) begin
        r_dat <= bus.rom_q;
      end

      if (w_step) begin
        r_addr <= w_step_up ? w_addr_up : w_addr_dn;
      end

      if (bus.key_mode_flag) begin
        r_tick <= '0;
        case (r_mode)
          MODE_MANUAL:  r_mode <= MODE_AUTO_UP;
          MODE_AUTO_UP: r_mode <= MODE_AUTO_DOWN;
          default:      r_mode <= MODE_MANUAL;
        endcase
      end else begin
        case (r_mode)
          MODE_MANUAL: begin
            r_tick <= '0;
          end
          MODE_AUTO_UP: begin
            if (w_key_dn) begin
              r_mode <= MODE_AUTO_DOWN;
              r_tick <= '0;
            end else if (w_key_up) begin
              r_tick <= '0;
            end else if (w_tick_wrap) begin
              r_tick <= '0;
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
          MODE_AUTO_DOWN: begin
            if (w_key_up) begin
              r_mode <= MODE_AUTO_UP;
              r_tick <= '0;
            end else if (w_key_dn) begin
              r_tick <= '0;
            end else if (w_tick_wrap) begin
              r_tick <= '0;
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
          default: begin
            // Encoding 11 is never entered deliberately; fall back to manual.
            r_mode <= MODE_MANUAL;
            r_tick <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign bus.rom_addr   = r_addr;
  assign bus.data_out   = r_dat;
  assign bus.data_valid = r_vld;
  assign bus.mode       = r_mode;

endmodule
